// File: rtl/immediate_splitter_pkg.sv
// ImmediatePkg
// Shared definitions for the immediate splitter slice: fixed word and
// immediate widths, the splitter state enum, and small helpers that describe
// how a 32-bit constant maps onto a (upper << 16) + signext16(lower) pair.
//
// Contents:
//   WORD_WIDTH    - width of the incoming constant (32)
//   IMM_WIDTH     - width of one emitted immediate field (16)
//   splitState_t  - IDLE / UPPER / LOWER
//   upperImm()    - upper field with the carry from the sign of the lower field
//   fitsImm()     - constant is representable as a sign-extended 16-bit value

package ImmediatePkg;

  localparam int WORD_WIDTH = 32;
  localparam int IMM_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UPPER = 2'd1,
    LOWER = 2'd2
  } splitState_t;

  // The consumer sign-extends the lower field, so a set bit 15 effectively
  // subtracts 0x10000. Adding bit 15 into the upper field cancels that out.
  // The sum deliberately wraps at 16 bits (0xFFFF + 1 -> 0x0000).
  function automatic logic [IMM_WIDTH-1:0] upperImm(input logic [WORD_WIDTH-1:0] word);
    return word[WORD_WIDTH-1:IMM_WIDTH] + {{(IMM_WIDTH-1){1'b0}}, word[IMM_WIDTH-1]};
  endfunction

  // A word fits in one immediate when bits 31..15 are all copies of the
  // same value, i.e. sign-extending bits 15..0 reproduces the whole word.
  function automatic logic fitsImm(input logic [WORD_WIDTH-1:0] word);
    return (&word[WORD_WIDTH-1:IMM_WIDTH-1]) || !(|word[WORD_WIDTH-1:IMM_WIDTH-1]);
  endfunction

endpackage

// File: rtl/immediate_splitter_core.sv
// ImmediateSplitCore
// Purely combinational split of a held 32-bit constant into the two 16-bit
// immediates a load-upper / add-immediate style instruction pair would use.
//
// Ports:
//   value  in  [31:0]  constant held by the splitter
//   upper  out [15:0]  upper field, already corrected for the lower sign
//   lower  out [15:0]  lower field, value[15:0]
//   fits   out         value needs only the lower field (sign-extended)

module ImmediateSplitCore
  import ImmediatePkg::*;
(
  input  logic [WORD_WIDTH-1:0] value,
  output logic [IMM_WIDTH-1:0]  upper,
  output logic [IMM_WIDTH-1:0]  lower,
  output logic                  fits
);

  // The lower field is taken verbatim; all of the arithmetic lives in the
  // upper field so that (upper << 16) + signext16(lower) rebuilds value.
  always_comb begin
    upper = upperImm(value);
    lower = value[IMM_WIDTH-1:0];
    fits  = fitsImm(value);
  end

endmodule

// File: rtl/immediate_splitter.sv
// immediate_splitter
// Accepts one 32-bit constant at a time and emits it as 16-bit immediates:
// the upper part first (outIsUpper=1), then the lower part (outLast=1).
// Both sides use a valid/ready handshake; a constant is accepted only when
// the splitter is idle, and the held constant is dropped on reset.
//
// Configuration:
//   IMM_SPLIT_FAST_EN  when defined, constants that fit in a sign-extended
//                      16-bit immediate skip the upper part and emit only the
//                      lower chunk (with outLast=1). When undefined every
//                      constant emits two chunks.
//
// Ports:
//   clock       in         rising-edge clock
//   reset       in         asynchronous active-high reset
//   inValid     in         a constant is offered on inValue
//   inValue     in  [31:0] constant to split
//   inReady     out        splitter is idle and will take a constant
//   outValid    out        outChunk holds an immediate
//   outChunk    out [15:0] immediate field (0 when outValid=0)
//   outIsUpper  out        outChunk is the upper (shift-by-16) part
//   outLast     out        outChunk is the final chunk of the constant
//   outReady    in         consumer takes outChunk this cycle

module immediate_splitter
  import ImmediatePkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inValid,
  input  logic [WORD_WIDTH-1:0] inValue,
  output logic                  inReady,
  output logic                  outValid,
  output logic [IMM_WIDTH-1:0]  outChunk,
  output logic                  outIsUpper,
  output logic                  outLast,
  input  logic                  outReady
);

  splitState_t           state;
  splitState_t           stateNext;
  logic [WORD_WIDTH-1:0] valueReg;
  logic [IMM_WIDTH-1:0]  upperPart;
  logic [IMM_WIDTH-1:0]  lowerPart;
  logic                  heldFitsUnused;
  logic                  inXfer;
  logic                  outXfer;

  // The fits flag of the held word is not consulted: the fast path has to
  // decide on the incoming word so it can skip UPPER on the capture edge.
  ImmediateSplitCore core (
    .value (valueReg),
    .upper (upperPart),
    .lower (lowerPart),
    .fits  (heldFitsUnused)
  );

  assign inXfer  = inValid && inReady;
  assign outXfer = outValid && outReady;

  // State register. Reset is asynchronous so the outputs, which decode
  // straight from this register, drop to idle without waiting for a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Constant holding register. It only loads on an accepted input, so
  // inValid seen outside IDLE cannot disturb a constant being emitted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valueReg <= '0;
    end else if (inXfer) begin
      valueReg <= inValue;
    end
  end

  // Next-state logic. Each chunk state advances only on an output
  // handshake, which is what keeps the outputs stable under backpressure.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (inXfer) begin
`ifdef IMM_SPLIT_FAST_EN
          stateNext = fitsImm(inValue) ? LOWER : UPPER;
`else
          stateNext = UPPER;
`endif
        end
      end
      UPPER: begin
        if (outXfer) begin
          stateNext = LOWER;
        end
      end
      LOWER: begin
        if (outXfer) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Output decode. Everything defaults to zero so the chunk fields read as
  // 0 whenever no chunk is being offered.
  always_comb begin
    inReady    = 1'b0;
    outValid   = 1'b0;
    outChunk   = '0;
    outIsUpper = 1'b0;
    outLast    = 1'b0;
    case (state)
      IDLE: begin
        inReady = 1'b1;
      end
      UPPER: begin
        outValid   = 1'b1;
        outChunk   = upperPart;
        outIsUpper = 1'b1;
      end
      LOWER: begin
        outValid = 1'b1;
        outChunk = lowerPart;
        outLast  = 1'b1;
      end
      default: begin
        inReady = 1'b0;
      end
    endcase
  end

endmodule
